// File: rtl/ir_camera_tracker.sv
// IR camera tracker: writes a configuration table to the camera through i2c_master,
// then polls 16-byte position frames and publishes up to four decoded blobs per frame.
module ir_camera_tracker #(
    parameter int unsigned              NUM_CONFIG  = 3,
    parameter logic [NUM_CONFIG*16-1:0] CONFIG_DATA = 48'h300130083333,
    parameter logic [6:0]               I2C_ADDR    = 7'h58,
    parameter int unsigned              NUM_BLOBS   = 4,
    parameter int unsigned              GAP_CYCLES  = 100,
    parameter int unsigned              TIMEOUT     = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     i2c_start,
    output logic                     i2c_rw,
    output logic [6:0]               i2c_addr,
    output logic [7:0]               i2c_data,
    output logic [4:0]               i2c_packets,
    input  logic                     i2c_ready,
    input  logic                     i2c_data_req,
    input  logic [7:0]               i2c_data_in,
    input  logic                     i2c_data_valid,
    output logic [10*NUM_BLOBS-1:0]  x,
    output logic [10*NUM_BLOBS-1:0]  y,
    output logic [4*NUM_BLOBS-1:0]   size,
    output logic [NUM_BLOBS-1:0]     blob_valid,
    output logic                     frame_valid,
    output logic                     configured,
    output logic [7:0]               error_count
);
    localparam int unsigned SB = 3 * NUM_BLOBS;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_START, S_CFG_WAIT, S_CFG_GAP, S_REQ_START, S_REQ_WAIT,
        S_RD_START, S_RD_WAIT, S_PUBLISH, S_POLL_GAP
    } state_t;

    state_t                  r_state, w_next;
    logic                    r_start, r_rw, r_configured, r_frame_valid;
    logic [7:0]              r_data, r_err;
    logic [4:0]              r_packets, r_byte_cnt;
    logic [3:0]              r_cfg_idx;
    logic [7:0]              r_shadow [SB];
    logic [GW-1:0]           r_gap;
    logic [TW-1:0]           r_wd;
    logic [10*NUM_BLOBS-1:0] r_x, r_y, w_x, w_y;
    logic [4*NUM_BLOBS-1:0]  r_size, w_size;
    logic [NUM_BLOBS-1:0]    r_bv, w_bv;
    logic [15:0]             w_cfg_pair;
    logic w_wait, w_done, w_tmo, w_gap_in, w_gap_done, w_store, w_full, w_cfg_more, w_err_inc;

    assign i2c_start   = r_start;
    assign i2c_rw      = r_rw;
    assign i2c_addr    = I2C_ADDR;
    assign i2c_data    = r_data;
    assign i2c_packets = r_packets;
    assign x           = r_x;
    assign y           = r_y;
    assign size        = r_size;
    assign blob_valid  = r_bv;
    assign frame_valid = r_frame_valid;
    assign configured  = r_configured;
    assign error_count = r_err;

    // Start drops once the master reports busy, so start low plus ready high means done.
    assign w_wait     = r_state inside {S_CFG_WAIT, S_REQ_WAIT, S_RD_WAIT};
    assign w_done     = w_wait && !r_start && i2c_ready;
    assign w_tmo      = w_wait && !w_done && (r_wd == TW'(TIMEOUT - 1));
    assign w_gap_in   = r_state inside {S_CFG_GAP, S_POLL_GAP};
    assign w_gap_done = (r_gap == GW'(GAP_CYCLES - 1));
    assign w_store    = (r_state == S_RD_WAIT) && i2c_data_valid && (r_byte_cnt < 5'd16);
    assign w_full     = (r_byte_cnt == 5'd16) || (w_store && r_byte_cnt == 5'd15);
    assign w_cfg_more = r_cfg_idx < 4'(NUM_CONFIG);
    assign w_err_inc  = w_tmo || ((r_state == S_RD_WAIT) && w_done && !w_full);

    always_comb begin
        w_cfg_pair = '0;
        for (int unsigned i = 0; i < NUM_CONFIG; i++)
            if (r_cfg_idx == 4'(i)) w_cfg_pair = CONFIG_DATA[(NUM_CONFIG-1-i)*16 +: 16];
    end

    always_comb begin
        w_x = '0;
        w_y = '0;
        w_size = '0;
        w_bv = '0;
        for (int unsigned k = 0; k < NUM_BLOBS; k++) begin
            w_x[10*k +: 10]  = {r_shadow[3*k+2][5:4], r_shadow[3*k]};
            w_y[10*k +: 10]  = {r_shadow[3*k+2][7:6], r_shadow[3*k+1]};
            w_size[4*k +: 4] = r_shadow[3*k+2][3:0];
            w_bv[k]          = ~&{r_shadow[3*k], r_shadow[3*k+1], r_shadow[3*k+2]};
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (enable) w_next = r_configured ? S_REQ_START : S_CFG_START;
            S_CFG_START: w_next = S_CFG_WAIT;
            S_CFG_WAIT:  if (w_done) w_next = S_CFG_GAP; else if (w_tmo) w_next = S_IDLE;
            S_CFG_GAP:   if (w_gap_done) w_next = w_cfg_more ? S_CFG_START : S_REQ_START;
            S_REQ_START: w_next = S_REQ_WAIT;
            S_REQ_WAIT:  if (w_done) w_next = S_RD_START; else if (w_tmo) w_next = S_IDLE;
            S_RD_START:  w_next = S_RD_WAIT;
            S_RD_WAIT:   if (w_done) w_next = w_full ? S_PUBLISH : S_POLL_GAP;
                         else if (w_tmo) w_next = S_IDLE;
            S_PUBLISH:   w_next = S_POLL_GAP;
            S_POLL_GAP:  if (w_gap_done) w_next = enable ? S_REQ_START : S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start       <= 1'b0;
            r_rw          <= 1'b1;
            r_data        <= '0;
            r_packets     <= '0;
            r_cfg_idx     <= '0;
            r_configured  <= 1'b0;
            r_err         <= '0;
            r_byte_cnt    <= '0;
            r_gap         <= '0;
            r_wd          <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_size        <= '0;
            r_bv          <= '0;
            r_frame_valid <= 1'b0;
            for (int unsigned i = 0; i < SB; i++) r_shadow[i] <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_wd  <= w_wait ? r_wd + 1'b1 : '0;
            r_gap <= (w_gap_in && !w_gap_done) ? r_gap + 1'b1 : '0;
            if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (w_store) r_byte_cnt <= r_byte_cnt + 5'd1;
            // Byte 0 is a header and bytes past the last decoded blob are dropped.
            for (int unsigned i = 0; i < SB; i++)
                if (w_store && r_byte_cnt == 5'(i + 1)) r_shadow[i] <= i2c_data_in;

            unique case (r_state)
                S_CFG_START: begin
                    r_start   <= 1'b1;
                    r_rw      <= 1'b0;
                    r_packets <= 5'd2;
                    r_data    <= w_cfg_pair[15:8];
                end
                S_REQ_START: begin
                    r_start   <= 1'b1;
                    r_rw      <= 1'b0;
                    r_packets <= 5'd1;
                    r_data    <= 8'h36;
                end
                S_RD_START: begin
                    r_start    <= 1'b1;
                    r_rw       <= 1'b1;
                    r_packets  <= 5'd16;
                    r_byte_cnt <= '0;
                end
                S_CFG_WAIT, S_REQ_WAIT, S_RD_WAIT: begin
                    if (r_start && !i2c_ready) r_start <= 1'b0;
                    if (r_state == S_CFG_WAIT && i2c_data_req) r_data <= w_cfg_pair[7:0];
                    if (r_state == S_CFG_WAIT && w_done) r_cfg_idx <= r_cfg_idx + 4'd1;
                    if (w_tmo) begin
                        r_start      <= 1'b0;
                        r_configured <= 1'b0;
                        r_cfg_idx    <= '0;
                    end
                end
                S_CFG_GAP: if (w_gap_done && !w_cfg_more) r_configured <= 1'b1;
                S_PUBLISH: begin
                    r_x           <= w_x;
                    r_y           <= w_y;
                    r_size        <= w_size;
                    r_bv          <= w_bv;
                    r_frame_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
